// File: rtl/score_pkg.sv
// score_pkg: shared constants for score_keeper.
// Holds collision class codes, FSM state enum, BCD score type,
// pending-slot payload, seven-segment patterns and a decimal-to-BCD helper.
package score_pkg;

  localparam int unsigned DIGITS  = 6;
  localparam int unsigned CT_W    = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned PILLS_W = 10;
  localparam int unsigned LIVES_W = 2;

  // Collision classes; codes 5-15 behave like CT_EMPTY
  localparam logic [CT_W-1:0] CT_EMPTY = 4'd0;
  localparam logic [CT_W-1:0] CT_WALL  = 4'd1;
  localparam logic [CT_W-1:0] CT_PILL  = 4'd2;
  localparam logic [CT_W-1:0] CT_POWER = 4'd3;
  localparam logic [CT_W-1:0] CT_GHOST = 4'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Six BCD digits, digit 0 in [3:0]
  typedef logic [DIGITS-1:0][3:0] bcd_t;

  // One-entry holding slot for an event that arrives while busy
  typedef struct packed {
    logic            valid;
    logic [CT_W-1:0] ct;
  } slot_t;

  // Active-low segments, bit order gfedcba
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Decimal integer to six BCD digits (used at elaboration for point values)
  function automatic bcd_t to_bcd(input int unsigned value);
    bcd_t        r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = 4'(v % 10);
      v    = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_seg7.sv
// seg7_digit: one BCD digit to active-low seven-segment pattern.
// Ports: bcd (digit), blank (force all segments off), seg_c (segments).
// Illegal codes 10-15 also show blank.
module seg7_digit
  import score_pkg::*;
(
  input  logic [3:0]       bcd,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: applies committed Pac-Man moves to score, pills and lives.
// Ports: CLOCK_50/reset_n (sync active-low); done + collision_type event in;
// score_bcd, pills_left, lives, busy, level_clear, game_over, evt_drop
// (all registered); HEX0..HEX5 seven-segment view of score_bcd.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned PILL_POINTS  = 10,
  parameter int unsigned POWER_POINTS = 50,
  parameter int unsigned PILL_COUNT   = 300,
  parameter int unsigned START_LIVES  = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  done,
  input  logic [CT_W-1:0]       collision_type,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [PILLS_W-1:0]    pills_left,
  output logic [LIVES_W-1:0]    lives,
  output logic                  busy,
  output logic                  level_clear,
  output logic                  game_over,
  output logic                  evt_drop,
  output logic [SEG_W-1:0]      HEX0,
  output logic [SEG_W-1:0]      HEX1,
  output logic [SEG_W-1:0]      HEX2,
  output logic [SEG_W-1:0]      HEX3,
  output logic [SEG_W-1:0]      HEX4,
  output logic [SEG_W-1:0]      HEX5
);

  localparam bcd_t                PILL_BCD   = to_bcd(PILL_POINTS);
  localparam bcd_t                POWER_BCD  = to_bcd(POWER_POINTS);
  localparam logic [PILLS_W-1:0]  PILLS_INIT = PILLS_W'(PILL_COUNT);
  localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [2:0]          LAST_DIG   = 3'(DIGITS - 1);

  state_t               state_q, state_d;
  bcd_t                 score_q, score_d;
  bcd_t                 shadow_q, shadow_d;
  bcd_t                 addend_q, addend_d;
  logic                 carry_q, carry_d;
  logic [2:0]           idx_q, idx_d;
  logic [PILLS_W-1:0]   pills_q, pills_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 busy_q, busy_d;
  logic                 clear_q, clear_d;
  logic                 over_q, over_d;
  logic                 drop_q, drop_d;
  slot_t                slot_q, slot_d;

  logic                 ev_valid;
  logic [CT_W-1:0]      ev_ct;
  logic [4:0]           dsum;
  logic                 halted;

  assign halted = clear_q || over_q;

  // Next-state: event acceptance, serial BCD add, commit with saturation
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    shadow_d = shadow_q;
    addend_d = addend_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    pills_d  = pills_q;
    lives_d  = lives_q;
    busy_d   = busy_q;
    clear_d  = clear_q;
    over_d   = over_q;
    drop_d   = drop_q;
    slot_d   = slot_q;
    ev_valid = 1'b0;
    ev_ct    = CT_EMPTY;
    dsum     = '0;

    case (state_q)
      IDLE: begin
        // A held event takes priority; a fresh done is ignored that cycle
        if (slot_q.valid) begin
          ev_valid     = 1'b1;
          ev_ct        = slot_q.ct;
          slot_d.valid = 1'b0;
        end else if (done) begin
          ev_valid = 1'b1;
          ev_ct    = collision_type;
        end

        if (ev_valid && !halted) begin
          case (ev_ct)
            CT_PILL, CT_POWER: begin
              addend_d = (ev_ct == CT_PILL) ? PILL_BCD : POWER_BCD;
              carry_d  = 1'b0;
              idx_d    = 3'd0;
              state_d  = ADD;
              busy_d   = 1'b1;
              if (pills_q != '0) begin
                pills_d = pills_q - PILLS_W'(1);
                if (pills_q == PILLS_W'(1)) clear_d = 1'b1;
              end
            end
            CT_GHOST: begin
              if (lives_q != '0) begin
                lives_d = lives_q - LIVES_W'(1);
                if (lives_q == LIVES_W'(1)) over_d = 1'b1;
              end
            end
            CT_EMPTY, CT_WALL: ;
            default: ;
          endcase
        end
      end

      ADD: begin
        dsum = 5'(score_q[idx_q]) + 5'(addend_q[idx_q]) + 5'(carry_q);
        if (dsum > 5'd9) begin
          shadow_d[idx_q] = 4'(dsum - 5'd10);
          carry_d         = 1'b1;
        end else begin
          shadow_d[idx_q] = dsum[3:0];
          carry_d         = 1'b0;
        end
        if (idx_q == LAST_DIG) state_d = COMMIT;
        else                   idx_d   = idx_q + 3'd1;
      end

      COMMIT: begin
        score_d = carry_q ? {DIGITS{4'h9}} : shadow_q;
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Events arriving mid-addition are held once, further ones are lost
    if (busy_q && done && !halted) begin
      if (slot_q.valid) drop_d = 1'b1;
      else              slot_d = '{valid: 1'b1, ct: collision_type};
    end
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      score_q  <= '0;
      shadow_q <= '0;
      addend_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= 3'd0;
      pills_q  <= PILLS_INIT;
      lives_q  <= LIVES_INIT;
      busy_q   <= 1'b0;
      clear_q  <= 1'b0;
      over_q   <= 1'b0;
      drop_q   <= 1'b0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      shadow_q <= shadow_d;
      addend_q <= addend_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      pills_q  <= pills_d;
      lives_q  <= lives_d;
      busy_q   <= busy_d;
      clear_q  <= clear_d;
      over_q   <= over_d;
      drop_q   <= drop_d;
      slot_q   <= slot_d;
    end
  end

  assign score_bcd   = score_q;
  assign pills_left  = pills_q;
  assign lives       = lives_q;
  assign busy        = busy_q;
  assign level_clear = clear_q;
  assign game_over   = over_q;
  assign evt_drop    = drop_q;

  // Leading-zero blanking: a digit blanks when it and all higher digits are 0
  logic [DIGITS-1:0] blank_c;
  always_comb begin
    blank_c             = '0;
    blank_c[DIGITS-1]   = (score_q[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      blank_c[i] = blank_c[i+1] && (score_q[i] == 4'd0);
    end
    blank_c[0] = 1'b0;
  end

  logic [SEG_W-1:0] hex_c [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_hex
    seg7_digit u_seg (
      .bcd   (score_q[g]),
      .blank (blank_c[g]),
      .seg_c (hex_c[g])
    );
  end

  assign HEX0 = hex_c[0];
  assign HEX1 = hex_c[1];
  assign HEX2 = hex_c[2];
  assign HEX3 = hex_c[3];
  assign HEX4 = hex_c[4];
  assign HEX5 = hex_c[5];

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper.
// Three instances: defaults (a), saturation setup (b), two-pill map (c).
module tb_score_keeper;
  import score_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  ct;
  logic        done_a, done_b, done_c;

  logic [23:0] score_a, score_b, score_c;
  logic [9:0]  pills_a, pills_b, pills_c;
  logic [1:0]  lives_a, lives_b, lives_c;
  logic        busy_a, busy_b, busy_c;
  logic        lc_a, lc_b, lc_c;
  logic        go_a, go_b, go_c;
  logic        drop_a, drop_b, drop_c;
  logic [6:0]  hex_a [6];
  logic [6:0]  hex_b [6];
  logic [6:0]  hex_c [6];

  int          checks = 0;
  int          passed = 0;
  logic [23:0] exp_q [$];
  logic [23:0] exp;

  always #5 clk = ~clk;

  score_keeper u_a (
    .CLOCK_50(clk), .reset_n(reset_n), .done(done_a), .collision_type(ct),
    .score_bcd(score_a), .pills_left(pills_a), .lives(lives_a), .busy(busy_a),
    .level_clear(lc_a), .game_over(go_a), .evt_drop(drop_a),
    .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]),
    .HEX3(hex_a[3]), .HEX4(hex_a[4]), .HEX5(hex_a[5])
  );

  score_keeper #(.PILL_POINTS(999990), .POWER_POINTS(10), .PILL_COUNT(5)) u_b (
    .CLOCK_50(clk), .reset_n(reset_n), .done(done_b), .collision_type(ct),
    .score_bcd(score_b), .pills_left(pills_b), .lives(lives_b), .busy(busy_b),
    .level_clear(lc_b), .game_over(go_b), .evt_drop(drop_b),
    .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]),
    .HEX3(hex_b[3]), .HEX4(hex_b[4]), .HEX5(hex_b[5])
  );

  score_keeper #(.PILL_COUNT(2)) u_c (
    .CLOCK_50(clk), .reset_n(reset_n), .done(done_c), .collision_type(ct),
    .score_bcd(score_c), .pills_left(pills_c), .lives(lives_c), .busy(busy_c),
    .level_clear(lc_c), .game_over(go_c), .evt_drop(drop_c),
    .HEX0(hex_c[0]), .HEX1(hex_c[1]), .HEX2(hex_c[2]),
    .HEX3(hex_c[3]), .HEX4(hex_c[4]), .HEX5(hex_c[5])
  );

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
  endtask

  // Present one event to an instance; returns just after the sampling edge
  task automatic pulse(input int which, input logic [3:0] c);
    ct = c;
    if (which == 0) done_a = 1'b1;
    else if (which == 1) done_b = 1'b1;
    else done_c = 1'b1;
    tick(1);
    done_a = 1'b0;
    done_b = 1'b0;
    done_c = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    checks++; if (score_a !== 24'h0) $display("FAIL rst_score got %h want 000000", score_a); else passed++;
    checks++; if (pills_a !== 10'd300) $display("FAIL rst_pills got %0d want 300", pills_a); else passed++;
    checks++; if (lives_a !== 2'd3) $display("FAIL rst_lives got %0d want 3", lives_a); else passed++;
    checks++; if ({busy_a, lc_a, go_a, drop_a} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {busy_a, lc_a, go_a, drop_a}); else passed++;
    checks++; if (hex_a[0] !== 7'h40) $display("FAIL rst_hex0 got %h want 40", hex_a[0]); else passed++;
    for (int i = 1; i < 6; i++) begin
      checks++; if (hex_a[i] !== 7'h7F) $display("FAIL rst_hex%0d got %h want 7f", i, hex_a[i]); else passed++;
    end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_pill();
    do_reset();
    exp_q.push_back(24'h000010);
    pulse(0, CT_PILL);
    tick(1);
    checks++; if (pills_a !== 10'd299) $display("FAIL pill_pills got %0d want 299", pills_a); else passed++;
    checks++; if (busy_a !== 1'b1) $display("FAIL pill_busy_t1 got %b want 1", busy_a); else passed++;
    tick(5);
    checks++; if (score_a !== 24'h0) $display("FAIL pill_early got %h want 000000", score_a); else passed++;
    checks++; if (busy_a !== 1'b1) $display("FAIL pill_busy_t6 got %b want 1", busy_a); else passed++;
    tick(1);
    exp = exp_q.pop_front();
    checks++; if (score_a !== exp) $display("FAIL pill_score got %h want %h", score_a, exp); else passed++;
    checks++; if (hex_a[1] !== 7'h79) $display("FAIL pill_hex1 got %h want 79", hex_a[1]); else passed++;
    checks++; if (hex_a[0] !== 7'h40) $display("FAIL pill_hex0 got %h want 40", hex_a[0]); else passed++;
    for (int i = 2; i < 6; i++) begin
      checks++; if (hex_a[i] !== 7'h7F) $display("FAIL pill_hex%0d got %h want 7f", i, hex_a[i]); else passed++;
    end
    tick(1);
    checks++; if (busy_a !== 1'b0) $display("FAIL pill_busy_end got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(24'h000010);
    exp_q.push_back(24'h000020);
    ct = CT_PILL;
    done_a = 1'b1;
    tick(3);
    done_a = 1'b0;
    checks++; if (drop_a !== 1'b1) $display("FAIL b2b_drop got %b want 1", drop_a); else passed++;
    tick(5);
    exp = exp_q.pop_front();
    checks++; if (score_a !== exp) $display("FAIL b2b_first got %h want %h", score_a, exp); else passed++;
    checks++; if (pills_a !== 10'd299) $display("FAIL b2b_pills_t7 got %0d want 299", pills_a); else passed++;
    tick(1);
    checks++; if (pills_a !== 10'd298) $display("FAIL b2b_pills_t8 got %0d want 298", pills_a); else passed++;
    checks++; if (busy_a !== 1'b1) $display("FAIL b2b_busy_t8 got %b want 1", busy_a); else passed++;
    tick(6);
    checks++; if (score_a !== 24'h000010) $display("FAIL b2b_early got %h want 000010", score_a); else passed++;
    tick(1);
    exp = exp_q.pop_front();
    checks++; if (score_a !== exp) $display("FAIL b2b_second got %h want %h", score_a, exp); else passed++;
    tick(1);
    checks++; if (busy_a !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy_a); else passed++;
    checks++; if (pills_a !== 10'd298) $display("FAIL b2b_pills_end got %0d want 298", pills_a); else passed++;
  endtask

  task automatic test_reset_abort();
    do_reset();
    pulse(0, CT_PILL);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    checks++; if (score_a !== 24'h0) $display("FAIL abort_score got %h want 000000", score_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_a); else passed++;
    checks++; if (pills_a !== 10'd300) $display("FAIL abort_pills got %0d want 300", pills_a); else passed++;
    checks++; if (hex_a[0] !== 7'h40 || hex_a[1] !== 7'h7F || hex_a[5] !== 7'h7F)
      $display("FAIL abort_hex got %h/%h/%h want 40/7f/7f", hex_a[0], hex_a[1], hex_a[5]); else passed++;
    reset_n = 1'b1;
    tick(10);
    checks++; if (score_a !== 24'h0 || busy_a !== 1'b0) $display("FAIL abort_resume got %h/%b want 000000/0", score_a, busy_a); else passed++;
  endtask

  task automatic test_no_effect();
    exp_q.push_back(24'h0);
    pulse(0, CT_WALL);
    tick(3);
    pulse(0, 4'd9);
    tick(9);
    exp = exp_q.pop_front();
    checks++; if (score_a !== exp) $display("FAIL noeff_score got %h want %h", score_a, exp); else passed++;
    checks++; if (pills_a !== 10'd300 || lives_a !== 2'd3) $display("FAIL noeff_counts got %0d/%0d want 300/3", pills_a, lives_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL noeff_busy got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_ghost();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(0, CT_GHOST);
      tick(1);
      checks++; if (lives_a !== 2'(2 - i)) $display("FAIL ghost_lives%0d got %0d want %0d", i, lives_a, 2 - i); else passed++;
      checks++; if (busy_a !== 1'b0) $display("FAIL ghost_busy%0d got %b want 0", i, busy_a); else passed++;
      tick(8);
    end
    checks++; if (go_a !== 1'b1) $display("FAIL ghost_over got %b want 1", go_a); else passed++;
    exp_q.push_back(24'h0);
    pulse(0, CT_PILL);
    tick(10);
    exp = exp_q.pop_front();
    checks++; if (score_a !== exp) $display("FAIL ghost_ignored got %h want %h", score_a, exp); else passed++;
    checks++; if (pills_a !== 10'd300) $display("FAIL ghost_pills got %0d want 300", pills_a); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    exp_q.push_back(24'h999990);
    pulse(1, CT_PILL);
    tick(7);
    exp = exp_q.pop_front();
    checks++; if (score_b !== exp) $display("FAIL sat_preload got %h want %h", score_b, exp); else passed++;
    checks++; if (hex_b[5] !== 7'h10 || hex_b[0] !== 7'h40) $display("FAIL sat_hex got %h/%h want 10/40", hex_b[5], hex_b[0]); else passed++;
    exp_q.push_back(24'h999999);
    pulse(1, CT_POWER);
    tick(7);
    exp = exp_q.pop_front();
    checks++; if (score_b !== exp) $display("FAIL sat_carry got %h want %h", score_b, exp); else passed++;
    exp_q.push_back(24'h999999);
    pulse(1, CT_POWER);
    tick(7);
    exp = exp_q.pop_front();
    checks++; if (score_b !== exp) $display("FAIL sat_hold got %h want %h", score_b, exp); else passed++;
    checks++; if (pills_b !== 10'd2) $display("FAIL sat_pills got %0d want 2", pills_b); else passed++;
  endtask

  task automatic test_level_clear();
    do_reset();
    exp_q.push_back(24'h000010);
    pulse(2, CT_PILL);
    tick(1);
    checks++; if (pills_c !== 10'd1 || lc_c !== 1'b0) $display("FAIL lc_first got %0d/%b want 1/0", pills_c, lc_c); else passed++;
    tick(6);
    exp = exp_q.pop_front();
    checks++; if (score_c !== exp) $display("FAIL lc_score1 got %h want %h", score_c, exp); else passed++;
    exp_q.push_back(24'h000060);
    pulse(2, CT_POWER);
    tick(1);
    checks++; if (pills_c !== 10'd0 || lc_c !== 1'b1) $display("FAIL lc_clear got %0d/%b want 0/1", pills_c, lc_c); else passed++;
    tick(6);
    exp = exp_q.pop_front();
    checks++; if (score_c !== exp) $display("FAIL lc_score2 got %h want %h", score_c, exp); else passed++;
    exp_q.push_back(24'h000060);
    pulse(2, CT_PILL);
    tick(10);
    exp = exp_q.pop_front();
    checks++; if (score_c !== exp || pills_c !== 10'd0) $display("FAIL lc_ignored got %h/%0d want %h/0", score_c, pills_c, exp); else passed++;
    checks++; if (busy_c !== 1'b0) $display("FAIL lc_busy got %b want 0", busy_c); else passed++;
  endtask

  initial begin
    reset_n = 1'b0;
    ct      = 4'd0;
    done_a  = 1'b0;
    done_b  = 1'b0;
    done_c  = 1'b0;
    test_reset();
    test_pill();
    test_back_to_back();
    test_reset_abort();
    test_no_effect();
    test_ghost();
    test_saturate();
    test_level_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
